// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its consumers.
// The sequencer attaches to the slave side. The master side drives the lock flag and the requests.
interface pll_reset_sequencer_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 locked;
  logic                 soft_reset_req;
  logic                 clear_fault;
  logic                 sys_reset;
  logic                 ready;
  logic                 lock_fault;
  logic [CNT_WIDTH-1:0] lock_loss_count;

  modport master (
    output locked,
    output soft_reset_req,
    output clear_fault,
    input  sys_reset,
    input  ready,
    input  lock_fault,
    input  lock_loss_count
  );

  modport slave (
    input  locked,
    input  soft_reset_req,
    input  clear_fault,
    output sys_reset,
    output ready,
    output lock_fault,
    output lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Generates the design-wide synchronous reset from the PLL lock flag.
// Reset is released only after lock has been stable for a programmable window, and loss-of-lock diagnostics are kept.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  pll_reset_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0]        HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]        STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]        TMR_ONE     = CW'(1);
  localparam logic [CNT_WIDTH-1:0] LOSS_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LOSS_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [CW-1:0]          tmr_r;
  logic [CW-1:0]          tmr_nx_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic                   lost_entry_s;
  logic                   sys_reset_r;
  logic                   ready_r;
  logic                   lock_fault_r;
  logic [CNT_WIDTH-1:0]   loss_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == LOSS_MAX) begin
      r = LOSS_MAX;
    end else begin
      r = v + LOSS_ONE;
    end
    return r;
  endfunction

  assign locked_s     = sync_r[SYNC_STAGES-1];
  assign lost_entry_s = (state_r == ST_RUN) && (state_nx_s == ST_LOST);

  // Synchronizer chain that brings the asynchronous lock flag into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.locked};
    end
  end

  // State and shared hold/stable timer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_HOLD;
      tmr_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      tmr_r   <= tmr_nx_s;
    end
  end

  // Next-state logic; the timer restarts from zero on every state change
  always_comb begin
    state_nx_s = state_r;
    tmr_nx_s   = tmr_r;
    case (state_r)
      ST_HOLD: begin
        if (bus.soft_reset_req) begin
          tmr_nx_s = '0;
        end else if (tmr_r == HOLD_LAST) begin
          state_nx_s = ST_WAIT_LOCK;
          tmr_nx_s   = '0;
        end else begin
          tmr_nx_s = tmr_r + TMR_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.soft_reset_req) begin
          state_nx_s = ST_HOLD;
          tmr_nx_s   = '0;
        end else if (locked_s) begin
          state_nx_s = ST_STABLE;
          tmr_nx_s   = '0;
        end else begin
          state_nx_s = ST_WAIT_LOCK;
          tmr_nx_s   = '0;
        end
      end
      ST_STABLE: begin
        if (bus.soft_reset_req) begin
          state_nx_s = ST_HOLD;
          tmr_nx_s   = '0;
        end else if (!locked_s) begin
          state_nx_s = ST_WAIT_LOCK;
          tmr_nx_s   = '0;
        end else if (tmr_r == STABLE_LAST) begin
          state_nx_s = ST_RUN;
          tmr_nx_s   = '0;
        end else begin
          tmr_nx_s = tmr_r + TMR_ONE;
        end
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous soft request so that it is always recorded
        if (!locked_s) begin
          state_nx_s = ST_LOST;
          tmr_nx_s   = '0;
        end else if (bus.soft_reset_req) begin
          state_nx_s = ST_HOLD;
          tmr_nx_s   = '0;
        end else begin
          state_nx_s = ST_RUN;
          tmr_nx_s   = '0;
        end
      end
      ST_LOST: begin
        state_nx_s = ST_HOLD;
        tmr_nx_s   = '0;
      end
      default: begin
        state_nx_s = ST_HOLD;
        tmr_nx_s   = '0;
      end
    endcase
  end

  // Outputs registered from the next state so they track the state register exactly
  always_ff @(posedge clock) begin
    if (reset) begin
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      sys_reset_r <= (state_nx_s != ST_RUN);
      ready_r     <= (state_nx_s == ST_RUN);
    end
  end

  // Sticky fault flag and saturating loss counter; a loss in the clearing cycle still counts once
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_fault_r <= 1'b0;
      loss_cnt_r   <= '0;
    end else if (lost_entry_s) begin
      lock_fault_r <= 1'b1;
      if (bus.clear_fault) begin
        loss_cnt_r <= LOSS_ONE;
      end else begin
        loss_cnt_r <= sat_inc(loss_cnt_r);
      end
    end else if (bus.clear_fault) begin
      lock_fault_r <= 1'b0;
      loss_cnt_r   <= '0;
    end else begin
      lock_fault_r <= lock_fault_r;
      loss_cnt_r   <= loss_cnt_r;
    end
  end

  assign bus.sys_reset       = sys_reset_r;
  assign bus.ready           = ready_r;
  assign bus.lock_fault      = lock_fault_r;
  assign bus.lock_loss_count = loss_cnt_r;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper, in the 63 MHz PLL output domain.
- Consumes the PLL's raw `locked` flag and generates the design-wide synchronous system reset.
- Releases reset only after lock has been stable for a programmable time.
- Re-asserts reset on loss of lock or on software request, and keeps a sticky fault flag plus a saturating loss-of-lock counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of flops in the `locked` synchronizer (min 2).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before releasing reset (min 1).
- HOLD_CYCLES, 16, minimum cycles reset is held after `reset`, lock loss or soft request (min 1).
- CNT_WIDTH, 8, width of the loss-of-lock counter.

Ports:
- clock  in  1  PLL output clock (63 MHz).
- reset  in  1  synchronous, active-high block reset.
- locked  in  1  raw PLL lock flag, asynchronous to `clock`.
- soft_reset_req  in  1  single-cycle request to re-run the reset sequence.
- clear_fault  in  1  single-cycle clear of `lock_fault` and `lock_loss_count`.
- sys_reset  out  1  active-high system reset to the rest of the design.
- ready  out  1  high when the system is out of reset (`ready == !sys_reset`).
- lock_fault  out  1  sticky: lock was lost while in RUN.
- lock_loss_count  out  CNT_WIDTH  number of RUN-state lock losses, saturating at all-ones.

Behaviour:
- Clock and reset: one clock domain. `reset` is synchronous and active-high, and takes priority over every other input.
- Reset values: state=HOLD, hold/stable counter=0, all synchronizer flops=0, `sys_reset`=1, `ready`=0, `lock_fault`=0, `lock_loss_count`=0.
- Synchronizer: `locked` passes through SYNC_STAGES flops to form `locked_s`. A raw edge captured at edge A is visible on `locked_s` after edge A+SYNC_STAGES-1.
- Output decode: outputs are decoded from the state register only, so they are glitch-free. `sys_reset` = (state != RUN). `ready` = (state == RUN).
- States:
  - HOLD: counter increments each cycle. When counter == HOLD_CYCLES-1, go to WAIT_LOCK and clear the counter. `soft_reset_req` here restarts the counter at 0.
  - WAIT_LOCK: if `locked_s`=1, go to STABLE with counter=0. `soft_reset_req` goes to HOLD.
  - STABLE:
    - `locked_s`=0 returns to WAIT_LOCK with counter cleared. This is not a fault and is not counted.
    - Otherwise the counter increments; when counter == STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
    - `soft_reset_req` goes to HOLD.
  - RUN:
    - `locked_s`=0 goes to LOST.
    - Otherwise `soft_reset_req` goes to HOLD (not counted).
    - Lock loss has priority over a simultaneous soft request.
  - LOST: single cycle, then unconditionally to HOLD with counter=0. On entry to LOST, `lock_fault` is set and `lock_loss_count` increments (holding at 2^CNT_WIDTH-1 when saturated).
- Timing (raw `locked` rises, captured at edge A, SYNC_STAGES=2): WAIT_LOCK samples `locked_s` at edge A+2. `ready` rises after edge A+2+STABLE_CYCLES.
- Loss timing (raw `locked` falls, captured at edge B in RUN): `sys_reset` rises after edge B+2. It stays high for at least 1 (LOST) + HOLD_CYCLES cycles plus the full WAIT_LOCK/STABLE sequence.
- `clear_fault`: zeros `lock_fault` and `lock_loss_count`. If a LOST entry occurs in the same cycle, the result is `lock_fault`=1 and count=1.
- Counter width: clog2(max(HOLD_CYCLES, STABLE_CYCLES)). The counter never wraps; it is cleared on every state transition.
- `locked` glitches shorter than one clock may be missed entirely; no debouncing is required beyond the STABLE window.

Test Plan:
(Parameters SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_WIDTH=2 unless stated.)
- Power-up: assert `reset` 3 cycles with `locked`=1, then release at edge R → `sys_reset`=1 through HOLD (4 cycles). `ready` rises exactly 4+1+8 = 13 edges after R; count=0, fault=0.
- Late lock: hold `locked`=0 for 50 cycles after HOLD, then raise at edge A → `ready` rises after edge A+10 and not earlier.
- Lock bounce during STABLE: `locked` high 5 cycles, low 1, then high → `ready` rises 10 edges after the final rise; `lock_fault`=0, count=0.
- Loss in RUN, repeated 4 times → each loss raises `sys_reset` 2 edges after the drop, for at least 5 cycles. `lock_fault`=1; count goes 1, 2, 3, 3 (saturates).
- `clear_fault` in the same cycle as LOST entry → count=1, `lock_fault`=1. A later lone `clear_fault` → 0, 0.
- `soft_reset_req` in RUN → `sys_reset` high for 4 HOLD cycles plus 9 cycles of WAIT_LOCK/STABLE, count unchanged. `reset` asserted mid-STABLE → HOLD with all outputs at reset values on the next edge.
